// File: rtl/scmp_bus_pak.sv
// Shared definitions for the SC/MP external bus-cycle controller:
// bus-cycle state encoding and status-byte layout.
package scmp_bus_pak;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ADDR,
    DATA,
    RECOV
  } BUS_STATE_t;

  // Status byte driven on D during the address strobe
  localparam int STAT_F_R     = 0;
  localparam int STAT_F_I     = 1;
  localparam int STAT_F_D     = 2;
  localparam int STAT_F_H     = 3;
  localparam int STAT_AHI_LSB = 4;

  // flags arrive as {F_H, F_D, F_I, F_R}; addr_hi is address bits 15:12
  function automatic logic [7:0] status_byte(input logic [3:0] addr_hi,
                                             input logic [3:0] flags);
    logic [7:0] s;
    s                       = '0;
    s[STAT_AHI_LSB +: 4]    = addr_hi;
    s[STAT_F_H]             = flags[3];
    s[STAT_F_D]             = flags[2];
    s[STAT_F_I]             = flags[1];
    s[STAT_F_R]             = flags[0];
    return s;
  endfunction

endpackage

// File: rtl/scmp_bus_arb.sv
// Bus arbitration for the SC/MP bus controller: registered BREQ,
// daisy-chained grant pass-through (ENOUT) and the ARB exit decode.
module scmp_bus_arb
  import scmp_bus_pak::*;
(
  input  logic       clk,
  input  logic       rst,
  input  BUS_STATE_t state,
  input  logic       cyc_req,
  input  logic       bus_ENIN,
  output logic       arb_go,
  output logic       arb_abort,
  output logic       bus_BREQ,
  output logic       bus_ENOUT
);

  // ARB exit conditions; abort takes priority over a grant in the same cycle
  always_comb begin
    arb_abort = (state == ARB) & ~cyc_req;
    arb_go    = (state == ARB) & bus_ENIN;
    bus_ENOUT = bus_ENIN & (state == IDLE) & ~cyc_req;
  end

  // BREQ register: high whenever the next state is ARB through RECOV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_BREQ <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ARB: bus_BREQ <= cyc_req;
        RECOV:     bus_BREQ <= 1'b0;
        default:   bus_BREQ <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus-cycle controller. Turns a held sequencer request into
// a full external cycle (arbitration, address/status strobe, data strobe,
// recovery) and stalls the sequencer until the cycle completes.
// Optional: define SCMP_BUS_HOLD_EN to let bus_NHOLD stretch the data strobe.
module scmp_bus_ctl
  import scmp_bus_pak::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_req,
  input  logic        cyc_wr,
  input  logic [3:0]  cyc_flags,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        mc_stall,
  output logic        cyc_done,
  output logic [7:0]  rd_data,
  output logic [11:0] bus_A,
  output logic [7:0]  bus_D_o,
  output logic        bus_D_oe,
  input  logic [7:0]  bus_D_i,
  output logic        bus_ADS_n,
  output logic        bus_RD_n,
  output logic        bus_WR_n,
  input  logic        bus_NHOLD,
  output logic        bus_BREQ,
  input  logic        bus_ENIN,
  output logic        bus_ENOUT
);

  localparam int              CNT_W    = $clog2(STROBE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

  BUS_STATE_t       state;
  logic             lat_wr;
  logic [3:0]       lat_flags;
  logic [15:0]      lat_addr;
  logic [7:0]       lat_wdata;
  logic [CNT_W-1:0] cnt;
  logic             arb_go;
  logic             arb_abort;
  logic             hold_ok;

`ifdef SCMP_BUS_HOLD_EN
  assign hold_ok = bus_NHOLD;
`else
  logic unused_nhold;
  assign unused_nhold = bus_NHOLD;
  assign hold_ok      = 1'b1;
`endif

  // Sequencer stall: asserted for the whole request except the done cycle
  assign mc_stall = cyc_req & ~cyc_done;

  scmp_bus_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .cyc_req   (cyc_req),
    .bus_ENIN  (bus_ENIN),
    .arb_go    (arb_go),
    .arb_abort (arb_abort),
    .bus_BREQ  (bus_BREQ),
    .bus_ENOUT (bus_ENOUT)
  );

  // Cycle FSM; bus outputs are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, including the latched request fields, has an
    // async reset value so a reset mid-cycle leaves no stale bus drive.
    if (rst) begin
      state     <= IDLE;
      lat_wr    <= 1'b0;
      lat_flags <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      cyc_done  <= 1'b0;
      rd_data   <= '0;
      bus_A     <= '0;
      bus_D_o   <= '0;
      bus_D_oe  <= 1'b0;
      bus_ADS_n <= 1'b1;
      bus_RD_n  <= 1'b1;
      bus_WR_n  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden later in the same block when the cycle completes.
      cyc_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cyc_req) begin
            state     <= ARB;
            lat_wr    <= cyc_wr;
            lat_flags <= cyc_flags;
            lat_addr  <= cyc_addr;
            lat_wdata <= cyc_wdata;
          end
        end
        ARB: begin
          if (arb_abort) begin
            state <= IDLE;
          end else if (arb_go) begin
            state     <= ADDR;
            bus_ADS_n <= 1'b0;
            bus_A     <= lat_addr[11:0];
            bus_D_oe  <= 1'b1;
            bus_D_o   <= status_byte(lat_addr[15:12], lat_flags);
          end
        end
        ADDR: begin
          state     <= DATA;
          bus_ADS_n <= 1'b1;
          bus_RD_n  <= lat_wr;
          bus_WR_n  <= ~lat_wr;
          bus_D_oe  <= lat_wr;
          bus_D_o   <= lat_wr ? lat_wdata : 8'h00;
          cnt       <= CNT_LOAD;
        end
        DATA: begin
          if (cnt == '0 && hold_ok) begin
            state    <= RECOV;
            bus_RD_n <= 1'b1;
            bus_WR_n <= 1'b1;
            cyc_done <= 1'b1;
            if (!lat_wr) rd_data <= bus_D_i;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOV: begin
          state    <= IDLE;
          bus_A    <= '0;
          bus_D_oe <= 1'b0;
          bus_D_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
